// File: rtl/ula_pkg.sv
// Shared ula definitions: opcode encodings, BIST LFSR polynomial and BIST state encoding.
package ula_pkg;

  localparam logic [3:0] ULA_AND = 4'b0000;
  localparam logic [3:0] ULA_OR  = 4'b0001;
  localparam logic [3:0] ULA_ADD = 4'b0010;
  localparam logic [3:0] ULA_SUB = 4'b0110;
  localparam logic [3:0] ULA_SLT = 4'b0111;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam int          N_OPS     = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_CHECK,
    ST_NEXT,
    ST_DONE
  } bistState_t;

  function automatic logic [3:0] opAt(input logic [2:0] idx);
    case (idx)
      3'd0:    return ULA_AND;
      3'd1:    return ULA_OR;
      3'd2:    return ULA_ADD;
      3'd3:    return ULA_SUB;
      default: return ULA_SLT;
    endcase
  endfunction

  // Right-shifting Galois form of x^32+x^22+x^2+x+1
  function automatic logic [31:0] lfsrStep(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage

// File: rtl/ula_bist_ref.sv
// Combinational golden ula model used by the BIST to compute the expected result.
module ula_bist_ref
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ulaOp,
  output logic [WIDTH-1:0] expS
);

  always_comb begin
    expS = '0;
    case (ulaOp)
      ULA_AND: expS = a & b;
      ULA_OR:  expS = a | b;
      ULA_ADD: expS = a + b;
      ULA_SUB: expS = a - b;
      ULA_SLT: expS[0] = ($signed(a) < $signed(b));
      default: expS = '0;
    endcase
  end

endmodule

// File: rtl/ula_bist.sv
// BIST initiator for the ula: drives directed and LFSR vectors per opcode, checks S,
// counts mismatches and captures the first failing vector.
//
// state    | meaning
// ST_IDLE  | waiting for start after reset
// ST_DRIVE | register A/B/UlaOp for the current vector
// ST_WAIT  | settle down-counter running
// ST_CHECK | compare S with golden, update fail count/capture
// ST_NEXT  | advance vector/opcode indices
// ST_DONE  | run finished, results held until next start
module ula_bist
  import ula_pkg::*;
#(
  parameter int          WIDTH  = 32,
  parameter int          N_VECT = 16,
  parameter int          SETTLE = 1,
  parameter logic [31:0] SEED   = 32'hACE1_2468
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [3:0]       UlaOp,
  input  logic [WIDTH-1:0] S,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       fail_count,
  output logic [3:0]       fail_op,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_s
);

  localparam int VW = (N_VECT > 1) ? $clog2(N_VECT) : 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [VW-1:0] LAST_VEC  = VW'(N_VECT - 1);
  localparam logic [2:0]    LAST_OP   = 3'(N_OPS - 1);

  bistState_t      state;
  logic [VW-1:0]   vecIdx;
  logic [2:0]      opIdx;
  logic [CW-1:0]   waitCnt;
  logic [31:0]     lfsr;
  logic [31:0]     lfsrA;
  logic [31:0]     lfsrB;
  logic [WIDTH-1:0] expS;

  assign lfsrA = lfsrStep(lfsr);
  assign lfsrB = lfsrStep(lfsrA);

  ula_bist_ref #(.WIDTH(WIDTH)) uRef (
    .a     (A),
    .b     (B),
    .ulaOp (UlaOp),
    .expS  (expS)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      vecIdx     <= '0;
      opIdx      <= '0;
      waitCnt    <= '0;
      lfsr       <= SEED;
      A          <= '0;
      B          <= '0;
      UlaOp      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_count <= '0;
      fail_op    <= '0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_s     <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            fail_count <= '0;
            fail_op    <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_s     <= '0;
            lfsr       <= SEED;
            vecIdx     <= '0;
            opIdx      <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          UlaOp <= opAt(opIdx);
          if (vecIdx == '0) begin
            A <= WIDTH'(32'd20);
            B <= WIDTH'(32'd12);
          end else begin
            A    <= WIDTH'(lfsrA);
            B    <= WIDTH'(lfsrB);
            lfsr <= lfsrB;
          end
          waitCnt <= WAIT_LOAD;
          state   <= (SETTLE > 0) ? ST_WAIT : ST_CHECK;
        end
        ST_WAIT: begin
          if (waitCnt == '0) state <= ST_CHECK;
          else               waitCnt <= waitCnt - 1'b1;
        end
        ST_CHECK: begin
          if (S != expS) begin
            // fail_count==0 marks the first mismatch since it never returns to 0 within a run
            if (fail_count == '0) begin
              fail_op <= UlaOp;
              fail_a  <= A;
              fail_b  <= B;
              fail_s  <= S;
            end
            if (fail_count != 8'hFF) fail_count <= fail_count + 1'b1;
          end
          state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (vecIdx == LAST_VEC) begin
            vecIdx <= '0;
            if (opIdx == LAST_OP) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (fail_count == '0);
              state <= ST_DONE;
            end else begin
              opIdx <= opIdx + 1'b1;
              state <= ST_DRIVE;
            end
          end else begin
            vecIdx <= vecIdx + 1'b1;
            state  <= ST_DRIVE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
